mem_access_ctrl: RTL and testbench

//  Handshaked memory controller with its backing byte array; sits directly downstream of the MAR/MDR pair.

---
 rtl/mem_access_ctrl_pkg.sv | 29 ++
 rtl/mem_access_ctrl_ram_array.sv | 29 ++
 rtl/mem_access_ctrl.sv | 140 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: size/direction codes,
// FSM states and the alignment rule.
package mem_access_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } accState_t;

    // A request faults when it is misaligned for its size or uses the reserved size code.
    function automatic logic isFault(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            SZ_WORD: return offset != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_ram_array.sv
// Byte-wide backing store with a 4-byte combinational read port at a word index.
// Lane 3 (bits 31:24) maps to the lowest byte address, giving big-endian words.
module ram_array #(
    parameter int ADDR_BITS = 8
) (
    input  logic                 Clk,
    input  logic [ADDR_BITS-3:0] wordIdx,
    input  logic [3:0]           byteWe,
    input  logic [31:0]          wrData,
    output logic [31:0]          rdData
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [7:0] mem [DEPTH];

    assign rdData = {mem[{wordIdx, 2'd0}], mem[{wordIdx, 2'd1}],
                     mem[{wordIdx, 2'd2}], mem[{wordIdx, 2'd3}]};

    // Contents are deliberately not reset; only enabled lanes are written.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < 4; i++) begin
            if (byteWe[i]) begin
                mem[{wordIdx, 2'(3 - i)}] <= wrData[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Handshaked memory controller: captures one request, waits WAIT_CYCLES, performs
// the access and holds MFC until the control unit drops MemEn.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        MemEn,
    input  logic        RW,
    input  logic [1:0]  WordSel,
    input  logic [31:0] Addr,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MFC,
    output logic        Fault,
    output logic        Busy
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    accState_t            state, stateNext;
    logic [3:0]           counter, counterNext;
    logic                 capture, doAccess;
    logic                 reqRW;
    logic [1:0]           reqSize;
    logic [ADDR_BITS-1:0] reqAddr;
    logic [31:0]          reqData;
    logic [1:0]           offset;
    logic                 reqFault;
    logic [31:0]          rdWord, loadData, laneData;
    logic [3:0]           laneMask, byteWe;

    assign offset   = reqAddr[1:0];
    assign reqFault = isFault(reqSize, offset);
    assign MFC      = (state == DONE);
    assign Busy     = (state != IDLE);
    assign byteWe   = (doAccess && !reqFault && reqRW == RW_WRITE) ? laneMask : 4'b0000;

    ram_array #(.ADDR_BITS(ADDR_BITS)) uRam (
        .Clk    (Clk),
        .wordIdx(reqAddr[ADDR_BITS-1:2]),
        .byteWe (byteWe),
        .wrData (laneData),
        .rdData (rdWord)
    );

    // Lane steering: right-justify loads, replicate store data across the lanes it may hit.
    always_comb begin
        loadData = '0;
        laneMask = 4'b0000;
        laneData = '0;
        case (reqSize)
            SZ_BYTE: begin
                loadData = {24'h0, rdWord[8*(2'd3 - offset) +: 8]};
                laneMask = 4'b1000 >> offset;
                laneData = {4{reqData[7:0]}};
            end
            SZ_HALF: begin
                loadData = {16'h0, offset[1] ? rdWord[15:0] : rdWord[31:16]};
                laneMask = offset[1] ? 4'b0011 : 4'b1100;
                laneData = {2{reqData[15:0]}};
            end
            SZ_WORD: begin
                loadData = rdWord;
                laneMask = 4'b1111;
                laneData = reqData;
            end
            default: ;
        endcase
    end

    // Next-state logic; dropping MemEn in WAIT abandons the request without touching memory.
    always_comb begin
        stateNext   = state;
        counterNext = counter;
        capture     = 1'b0;
        doAccess    = 1'b0;
        case (state)
            IDLE: begin
                if (MemEn) begin
                    capture     = 1'b1;
                    counterNext = WAIT_LOAD;
                    stateNext   = WAIT;
                end
            end
            WAIT: begin
                if (!MemEn) begin
                    stateNext = IDLE;
                end else if (counter != 4'd0) begin
                    counterNext = counter - 4'd1;
                end else begin
                    doAccess  = 1'b1;
                    stateNext = DONE;
                end
            end
            DONE: begin
                if (!MemEn) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state   <= IDLE;
            counter <= '0;
            DataOut <= '0;
            Fault   <= 1'b0;
            reqRW   <= RW_READ;
            reqSize <= SZ_BYTE;
            reqAddr <= '0;
            reqData <= '0;
        end else begin
            state   <= stateNext;
            counter <= counterNext;
            if (capture) begin
                reqRW   <= RW;
                reqSize <= WordSel;
                reqAddr <= Addr[ADDR_BITS-1:0];
                reqData <= DataIn;
            end
            if (doAccess) begin
                Fault <= reqFault;
                if (reqFault) begin
                    DataOut <= '0;
                end else if (reqRW == RW_READ) begin
                    DataOut <= loadData;
                end
            end else if (state == DONE && !MemEn) begin
                Fault <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed handshake/alignment steps plus
// randomized transactions against a byte-array reference model.
module tb_mem_access_ctrl;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    logic        clk, clr, memEn, memEnFast, rw;
    logic [1:0]  wordSel;
    logic [31:0] addr, dataIn;
    logic [31:0] dataOut, dataOutFast;
    logic        mfc, mfcFast, fault, faultFast, busy, busyFast;

    bit          useFast;
    logic        curMfc, curFault, curBusy;
    logic [31:0] curData;

    int nCmp  = 0;
    int nFail = 0;

    logic [7:0] refMem [2][256];

    assign curMfc   = useFast ? mfcFast     : mfc;
    assign curFault = useFast ? faultFast   : fault;
    assign curBusy  = useFast ? busyFast    : busy;
    assign curData  = useFast ? dataOutFast : dataOut;

    mem_access_ctrl #(.ADDR_BITS(8), .WAIT_CYCLES(2)) dut (
        .Clk(clk), .Clr(clr), .MemEn(memEn), .RW(rw), .WordSel(wordSel),
        .Addr(addr), .DataIn(dataIn), .DataOut(dataOut), .MFC(mfc),
        .Fault(fault), .Busy(busy)
    );

    mem_access_ctrl #(.ADDR_BITS(8), .WAIT_CYCLES(0)) dutFast (
        .Clk(clk), .Clr(clr), .MemEn(memEnFast), .RW(rw), .WordSel(wordSel),
        .Addr(addr), .DataIn(dataIn), .DataOut(dataOutFast), .MFC(mfcFast),
        .Fault(faultFast), .Busy(busyFast)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: big-endian byte array, address wraps at 256, size must be naturally aligned.
    function automatic void modelAccess(input int d, input bit isRead, input logic [1:0] size,
                                        input logic [31:0] a32, input logic [31:0] data,
                                        output bit expFault, output logic [31:0] expOut);
        int a, n;
        a = int'(a32 % 256);
        n = (size == SZ_BYTE) ? 1 : (size == SZ_HALF) ? 2 : 4;
        expFault = (size == SZ_RSVD) || (a % n != 0);
        expOut = 32'h0;
        if (expFault) return;
        for (int k = 0; k < n; k++) begin
            if (isRead) expOut = (expOut << 8) | 32'(refMem[d][a + k]);
            else        refMem[d][a + k] = 8'(data >> (8 * (n - 1 - k)));
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full four-phase transaction; starts and ends 1 time unit after a rising edge.
    task automatic applyStimulus(input bit fast, input bit isRead, input logic [1:0] size,
                                 input logic [31:0] a32, input logic [31:0] data,
                                 input int hold, input string tag);
        bit          expFault;
        logic [31:0] expOut;
        int          lat;
        bit          checkData;
        useFast = fast;
        modelAccess(fast ? 1 : 0, isRead, size, a32, data, expFault, expOut);
        checkData = isRead || expFault;
        rw = isRead; wordSel = size; addr = a32; dataIn = data;
        if (fast) memEnFast = 1'b1; else memEn = 1'b1;
        @(posedge clk); #1;
        checkOutput({tag, "/busy"}, 32'(curBusy), 32'd1);
        rw = 1'($urandom); wordSel = 2'($urandom); addr = $urandom; dataIn = $urandom;
        lat = 0;
        while (!curMfc && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, "/latency"}, 32'(lat), fast ? 32'd1 : 32'd3);
        checkOutput({tag, "/fault"}, 32'(curFault), 32'(expFault));
        if (checkData) checkOutput({tag, "/data"}, curData, expOut);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checkOutput({tag, "/mfcHeld"}, 32'(curMfc), 32'd1);
            if (checkData) checkOutput({tag, "/dataHeld"}, curData, expOut);
        end
        memEn = 1'b0; memEnFast = 1'b0;
        @(posedge clk); #1;
        checkOutput({tag, "/mfcDrop"}, 32'(curMfc), 32'd0);
        checkOutput({tag, "/faultDrop"}, 32'(curFault), 32'd0);
        checkOutput({tag, "/busyDrop"}, 32'(curBusy), 32'd0);
        if (checkData) checkOutput({tag, "/dataKept"}, curData, expOut);
    endtask

    initial begin
        clr = 1'b0; memEn = 1'b0; memEnFast = 1'b0; useFast = 1'b0;
        rw = 1'b1; wordSel = SZ_BYTE; addr = '0; dataIn = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset/data", dataOut, 32'h0);
        checkOutput("reset/mfc", 32'(mfc), 32'd0);
        checkOutput("reset/fault", 32'(fault), 32'd0);
        checkOutput("reset/busy", 32'(busy), 32'd0);
        #2 clr = 1'b1;
        @(posedge clk); #1;

        // Fill the main array with known nonzero words
        for (int a = 0; a < 256; a += 4)
            applyStimulus(0, 0, SZ_WORD, 32'(a), $urandom | 32'h1, 0, "init");

        // Test 1: reset in the middle of WAIT of a store to 0x10
        applyStimulus(0, 1, SZ_WORD, 32'h10, 32'h0, 0, "t1/preRead");
        useFast = 1'b0;
        rw = 1'b0; wordSel = SZ_WORD; addr = 32'h10; dataIn = 32'hA5A5_5A5A; memEn = 1'b1;
        @(posedge clk); #1;
        checkOutput("t1/busyWait", 32'(busy), 32'd1);
        @(posedge clk); #2;
        clr = 1'b0;
        #1;
        checkOutput("t1/mfc", 32'(mfc), 32'd0);
        checkOutput("t1/busy", 32'(busy), 32'd0);
        checkOutput("t1/data", dataOut, 32'h0);
        memEn = 1'b0;
        #3 clr = 1'b1;
        @(posedge clk); #1;
        applyStimulus(0, 1, SZ_WORD, 32'h10, 32'h0, 0, "t1/postRead");

        // Test 2: word store then byte and word reads
        applyStimulus(0, 0, SZ_WORD, 32'h20, 32'hDEADBEEF, 0, "t2/store");
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 1, SZ_BYTE, 32'h20 + 32'(i), 32'h0, 0, $sformatf("t2/byte%0d", i));
        applyStimulus(0, 1, SZ_WORD, 32'h20, 32'h0, 0, "t2/word");
        checkOutput("t2/literal", dataOut, 32'hDEADBEEF);

        // Test 3: partial stores over the word
        applyStimulus(0, 0, SZ_HALF, 32'h22, 32'h0000_1234, 0, "t3/halfStore");
        applyStimulus(0, 1, SZ_WORD, 32'h20, 32'h0, 0, "t3/read1");
        checkOutput("t3/literal1", dataOut, 32'hDEAD1234);
        applyStimulus(0, 0, SZ_BYTE, 32'h21, 32'h0000_0055, 0, "t3/byteStore");
        applyStimulus(0, 1, SZ_WORD, 32'h20, 32'h0, 0, "t3/read2");
        checkOutput("t3/literal2", dataOut, 32'hDE551234);

        // Test 4: faulting requests leave memory untouched
        applyStimulus(0, 1, SZ_HALF, 32'h21, 32'h0, 0, "t4/halfMis");
        applyStimulus(0, 1, SZ_WORD, 32'h22, 32'h0, 0, "t4/wordMis");
        applyStimulus(0, 0, SZ_RSVD, 32'h20, 32'hFFFF_FFFF, 0, "t4/rsvd");
        applyStimulus(0, 0, SZ_WORD, 32'h23, 32'hFFFF_FFFF, 0, "t4/storeMis");
        applyStimulus(0, 1, SZ_WORD, 32'h20, 32'h0, 0, "t4/unchanged");
        checkOutput("t4/literal", dataOut, 32'hDE551234);

        // Test 5: long handshake, then a store abandoned during WAIT
        applyStimulus(0, 1, SZ_WORD, 32'h20, 32'h0, 5, "t5/hold");
        useFast = 1'b0;
        rw = 1'b0; wordSel = SZ_WORD; addr = 32'h30; dataIn = 32'h0BAD_F00D; memEn = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        memEn = 1'b0;
        @(posedge clk); #1;
        checkOutput("t5/abortBusy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("t5/abortMfc", 32'(mfc), 32'd0);
        end
        applyStimulus(0, 1, SZ_WORD, 32'h30, 32'h0, 0, "t5/noWrite");

        // Test 6: address wrap, and zero-wait instance
        applyStimulus(0, 0, SZ_WORD, 32'h0000_0104, 32'hCAFE_F00D, 0, "t6/wrapStore");
        applyStimulus(0, 1, SZ_WORD, 32'h0000_0004, 32'h0, 0, "t6/wrapRead");
        checkOutput("t6/wrapLiteral", dataOut, 32'hCAFE_F00D);
        applyStimulus(1, 0, SZ_WORD, 32'h20, 32'hDEADBEEF, 0, "t6/fastStore");
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 1, SZ_BYTE, 32'h20 + 32'(i), 32'h0, 1, $sformatf("t6/fastByte%0d", i));
        applyStimulus(1, 1, SZ_WORD, 32'h20, 32'h0, 0, "t6/fastWord");

        // Randomized traffic on the main instance
        for (int t = 0; t < 60; t++) begin
            logic [31:0] ra;
            ra = $urandom;
            if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
            applyStimulus(0, 1'($urandom), 2'($urandom_range(0, 3)), ra, $urandom,
                          int'($urandom_range(0, 2)), $sformatf("rand%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
